// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the N-master round-robin / fixed-priority bus arbiter.
// Combinational helpers only; no state.
package bus_arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_OWNED = 1'b1
  } arb_state_t;

  // Idle bus lines are parked at this level.
  localparam logic PARK_VALUE = 1'b0;

  // Index width that stays at least 1 bit for degenerate counts.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_if.sv
// Request/grant handshake bundle between bus masters and the arbiter.
// Masters drive req/lock; the arbiter answers with grant and owner status.
interface bus_arbiter_rr_if
  import bus_arb_pkg::*;
#(
  parameter int N_MASTERS = 4
);
  localparam int IDX_W = idx_w(N_MASTERS);

  logic [N_MASTERS-1:0] req;
  logic [N_MASTERS-1:0] lock;
  logic [N_MASTERS-1:0] grant;
  logic                 owner_valid;
  logic [IDX_W-1:0]     owner_idx;
  logic                 preempt;

  modport master (
    output req, lock,
    input  grant, owner_valid, owner_idx, preempt
  );

  modport slave (
    input  req, lock,
    output grant, owner_valid, owner_idx, preempt
  );

endinterface

// File: rtl/rr_select.sv
// Winner select: rotate the eligible mask to start after last_i, priority-encode, rotate back.
// Purely combinational; RR_MODE=0 degenerates to lowest-index-wins.
module rr_select
  import bus_arb_pkg::*;
#(
  parameter int N_MASTERS = 4,
  parameter int RR_MODE   = 1,
  localparam int IDX_W    = idx_w(N_MASTERS)
) (
  input  logic [N_MASTERS-1:0] eligible_i,
  input  logic [IDX_W-1:0]     last_i,
  output logic [IDX_W-1:0]     winner_o,
  output logic                 valid_o
);

  logic [IDX_W:0]       start;
  logic [IDX_W:0]       pos;
  logic [IDX_W:0]       sum;
  logic [N_MASTERS-1:0] rot;

  always_comb begin
    start = '0;
    if (RR_MODE != 0 && {1'b0, last_i} != (IDX_W+1)'(N_MASTERS - 1)) begin
      start = {1'b0, last_i} + 1'b1;
    end
    // Doubling the mask makes the wrap-around a plain right shift.
    rot = N_MASTERS'({eligible_i, eligible_i} >> start);
    pos = '0;
    for (int i = N_MASTERS - 1; i >= 0; i--) begin
      if (rot[i]) pos = (IDX_W+1)'(i);
    end
    sum = start + pos;
    if (sum >= (IDX_W+1)'(N_MASTERS)) sum = sum - (IDX_W+1)'(N_MASTERS);
    winner_o = sum[IDX_W-1:0];
    valid_o  = |eligible_i;
  end

endmodule

// File: rtl/bus_arbiter_rr.sv
// N-master bus arbiter with tenure preemption, per-owner lock and idle bus parking.
// Grant appears 1 cycle after req; dropping req or a revoke removes grant in the same cycle.
module bus_arbiter_rr
  import bus_arb_pkg::*;
#(
  parameter int N_MASTERS  = 4,
  parameter int RR_MODE    = 1,
  parameter int MAX_TENURE = 16,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  bus_arbiter_rr_if.slave       arb,
  output wire  [ADDR_W-1:0]     addr_bus_o,
  output wire  [DATA_W-1:0]     data_bus_o,
  output wire                   wr_bus_o,
  output wire                   rd_bus_o,
  output wire                   fc_bus_o,
  output wire  [DATA_W/8-1:0]   data_mask_bus_o
);

  localparam int IDX_W = idx_w(N_MASTERS);
  localparam int CNT_W = idx_w(MAX_TENURE + 1);
  localparam logic [CNT_W-1:0] TENURE_MAX = CNT_W'(MAX_TENURE);

  arb_state_t           state_q, state_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [IDX_W-1:0]     last_q, last_d;
  logic [CNT_W-1:0]     tenure_q, tenure_d;

  logic [N_MASTERS-1:0] owner_oh;
  logic [N_MASTERS-1:0] others;
  logic                 owner_req;
  logic                 owner_lock;
  logic                 revoke;
  logic                 bus_used;
  logic [IDX_W-1:0]     sel_idx;
  logic                 sel_vld;

  assign owner_oh   = (state_q == ARB_OWNED) ? (N_MASTERS'(1) << owner_q) : '0;
  // With no owner this is simply req, so one selector serves both arbitration cases.
  assign others     = arb.req & ~owner_oh;
  assign owner_req  = |(arb.req & owner_oh);
  assign owner_lock = |(arb.lock & owner_oh);
  assign revoke     = (MAX_TENURE != 0) && (state_q == ARB_OWNED) &&
                      (tenure_q == TENURE_MAX) && (|others) && !owner_lock;

  assign arb.grant       = (owner_req && !revoke) ? owner_oh : '0;
  assign arb.owner_valid = (state_q == ARB_OWNED);
  assign arb.owner_idx   = (state_q == ARB_OWNED) ? owner_q : '0;
  assign arb.preempt     = revoke;

  rr_select #(
    .N_MASTERS (N_MASTERS),
    .RR_MODE   (RR_MODE)
  ) u_sel (
    .eligible_i (others),
    .last_i     (last_q),
    .winner_o   (sel_idx),
    .valid_o    (sel_vld)
  );

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    tenure_d = tenure_q;
    case (state_q)
      ARB_IDLE: begin
        if (sel_vld) begin
          state_d  = ARB_OWNED;
          owner_d  = sel_idx;
          last_d   = sel_idx;
          tenure_d = '0;
        end
      end
      ARB_OWNED: begin
        if (owner_req && !revoke) begin
          // Tenure only accrues while someone else is waiting.
          if (!(|others)) begin
            tenure_d = '0;
          end else if (tenure_q != TENURE_MAX) begin
            tenure_d = tenure_q + 1'b1;
          end
        end else if (sel_vld) begin
          owner_d  = sel_idx;
          last_d   = sel_idx;
          tenure_d = '0;
        end else begin
          state_d  = ARB_IDLE;
          owner_d  = '0;
          tenure_d = '0;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ARB_IDLE;
      owner_q  <= '0;
      last_q   <= IDX_W'(N_MASTERS - 1);
      tenure_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      tenure_q <= tenure_d;
    end
  end

  assign bus_used        = |arb.grant;
  assign addr_bus_o      = bus_used ? 'z   : {ADDR_W{PARK_VALUE}};
  assign data_bus_o      = bus_used ? 'z   : {DATA_W{PARK_VALUE}};
  assign wr_bus_o        = bus_used ? 1'bz : PARK_VALUE;
  assign rd_bus_o        = bus_used ? 1'bz : PARK_VALUE;
  assign fc_bus_o        = bus_used ? 1'bz : PARK_VALUE;
  assign data_mask_bus_o = bus_used ? 'z   : {(DATA_W/8){PARK_VALUE}};

  a_grant_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(arb.grant));

endmodule

// File: doc/bus_arbiter_rr.md
Name: bus_arbiter_rr

Overview:
- N-master system bus arbiter. Parametrised successor of the two-master CPU/DMA arbiter.
- Grants exactly one master at a time. Selection is fixed-priority or round-robin.
- Optional maximum-tenure preemption, with a per-master lock that blocks preemption.
- Parks the shared tri-state bus at zero whenever no master is granted.
- Sits at the bus fabric top level, between CPU, DMA channels and debug masters and the shared address/data/control bus.

Parameters:
- N_MASTERS, 4, number of requesters (2..16); index 0 is highest fixed priority.
- RR_MODE, 1, 0 = fixed priority (lowest index wins), 1 = round-robin starting after the last owner.
- MAX_TENURE, 16, cycles an owner may hold the bus while others wait; 0 disables preemption.
- ADDR_W, 32, address bus width.
- DATA_W, 32, data bus width; mask width is DATA_W/8.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- req  input  N_MASTERS  per-master bus request, level-held.
- lock  input  N_MASTERS  per-master atomic lock; sampled only for the current owner.
- grant  output  N_MASTERS  one-hot (or zero) bus grant.
- owner_valid  output  1  a master currently owns the bus.
- owner_idx  output  $clog2(N_MASTERS)  index of the owner; 0 when !owner_valid.
- preempt  output  1  one-cycle pulse on the cycle an ownership is revoked by tenure expiry.
- addr_bus  output  ADDR_W  parked 0 when idle, else 'z.
- data_bus  output  DATA_W  parked 0 when idle, else 'z.
- wr_bus, rd_bus, fc_bus  output  1 each  parked 0 when idle, else 'z.
- data_mask_bus  output  DATA_W/8  parked 0 when idle, else 'z.

Behaviour:
- **Registered state.** owner_valid_q, owner_q, last_q (round-robin pointer), tenure_cnt (width $clog2(MAX_TENURE+1)).
- **Reset values.** owner_valid_q=0, owner_q=0, last_q=N_MASTERS-1 (so master 0 wins first in RR mode), tenure_cnt=0.
- **Outputs during reset.** grant=0, owner_valid=0, owner_idx=0, preempt=0, all bus lines driven 0.
- **Reset mid-tenure.** Grant drops immediately (asynchronous reset); the bus is parked in the same cycle.
- **Grant is combinational.** grant[i] = owner_valid_q && owner_q==i && req[i] && !revoke.
  - Dropping req removes the grant in the same cycle.
- **Bus parking.** bus_used = |grant. Bus outputs are 'z when bus_used, else 0.
- **States.**
  - IDLE (!owner_valid_q).
  - OWNED (owner_valid_q, tenure_cnt counting).
- **IDLE.** If |req, the next edge selects a winner: owner_valid_q=1, owner_q=winner, last_q=winner, tenure_cnt=0.
  - Latency from req rising to grant: 1 cycle.
- **OWNED, owner holds req.** tenure_cnt increments, saturating at MAX_TENURE. It counts only while some other req is asserted; otherwise it is held at 0.
- **OWNED, owner drops req.** The next edge performs a new arbitration among the remaining requesters, excluding the old owner for that edge.
  - If none remain → IDLE.
  - Handover turnaround: exactly 1 parked cycle between owners.
- **Revoke.** revoke = MAX_TENURE!=0 && tenure_cnt==MAX_TENURE && other req pending && !lock[owner_q].
  - When revoke is set: grant drops combinationally, preempt=1 for that cycle, and the next edge arbitrates excluding the old owner.
  - The old owner may re-request and competes normally afterwards.
- **Lock.** While lock[owner_q]=1, no preemption occurs. The counter stays saturated, so preemption fires on the first cycle lock drops if others are still waiting.
- **Fixed mode.** Winner is the lowest set index of the eligible requests.
- **RR mode.** Winner is the first set index scanning last_q+1 … wrapping to last_q.
  - Wrap-around at N_MASTERS-1 → 0 is required.
  - A single requester equal to last_q wins after a full scan.
- **Simultaneous events.** If the owner drops req on the same edge a new req rises, the new requester is eligible in that arbitration.
- **Stray requests.** Requests from non-owners never affect the current grant, apart from enabling the tenure count.
- **Invariant.** grant is at most one-hot in every cycle (checked by assertion).

Decomposition:
- Package bus_arb_pkg holds:
  - typedef enum {ARB_IDLE, ARB_OWNED} arb_state_t;
  - localparam function clog2-safe index width;
  - PARK_VALUE constant (0).
- One sub-module, rr_select: inputs eligible mask, last pointer and RR_MODE; outputs winner index and valid. It is purely combinational (double-width mask rotate plus priority encode).
- The top level holds the FSM, tenure counter and bus park drivers.

Test Plan:
- **Reset park.** rst=1 with req=4'b1111 → grant=0, addr_bus=0, data_bus=0; after release, grant=4'b0001 one cycle later.
- **Round-robin rotation.** RR_MODE=1, req=4'b1111 held, each owner drops req for 1 cycle after 3 cycles of tenure → grant sequence 0001,1-cycle park,0010,park,0100,park,1000,park,0001.
- **Fixed priority.** RR_MODE=0, req=4'b1010, owner 1 drops req → next grant 1000; if req[0] rises while master 3 owns the bus, master 3 keeps the bus until it drops req.
- **Tenure preemption.** MAX_TENURE=4, master 0 holds req, master 2 requests at cycle 0 → preempt=1 and grant=0 when tenure_cnt reaches 4, grant=0100 on the next cycle.
- **Lock.** Same as the preemption case with lock[0]=1 for 10 cycles → no preemption; preempt fires on the first cycle lock[0]=0; then master 2 is granted.
- **Bus parking and one-hot.** Random req/lock for 10k cycles with MAX_TENURE=8 → grant always one-hot or zero; bus lines are 0 exactly when grant==0; no master waits more than N_MASTERS*(MAX_TENURE+1) cycles while unlocked.
